// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin search helper for rr_arbiter_8
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Walk upward from ptr+1, wrapping, and return the first active request.
  function automatic rr_pick_t next_rr(input logic [N_REQ-1:0] req,
                                       input logic [IDX_W-1:0] ptr);
    rr_pick_t         pick;
    logic [IDX_W-1:0] k;
    pick.found = 1'b0;
    pick.idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = ptr + IDX_W'(i);
      if (!pick.found && req[k]) begin
        pick.found = 1'b1;
        pick.idx   = k;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// rtl/decoder_3_to_8.sv - binary index to one-hot decoder
module decoder_3_to_8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  always_comb begin
    onehot      = 8'b0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with grant hold and optional hold timeout
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             release_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HC_W'(MAX_HOLD - 1);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] idx_next;
  logic             valid_next;
  logic             timeout_next;
  logic [HC_W-1:0]  hold_cnt, hold_next;
  logic             hold_expired;
  rr_pick_t         pick;
  logic [N_REQ-1:0] idx_onehot;

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    idx_next     = grant_idx;
    valid_next   = grant_valid;
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
    pick         = next_rr(req, ptr);
    case (state)
      IDLE: begin
        if (pick.found) begin
          idx_next   = pick.idx;
          valid_next = 1'b1;
          hold_next  = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_grant || !req[grant_idx] || hold_expired) begin
          // Timeout only reported when neither release nor withdrawal ended the grant.
          timeout_next = !release_grant && req[grant_idx];
          ptr_next     = grant_idx;
          valid_next   = 1'b0;
          state_next   = IDLE;
        end else begin
          hold_next = hold_cnt + HC_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N_REQ - 1);
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      grant_idx   <= idx_next;
      grant_valid <= valid_next;
      hold_cnt    <= hold_next;
      timeout     <= timeout_next;
    end
  end

  decoder_3_to_8 u_decoder (
    .idx    (grant_idx),
    .onehot (idx_onehot)
  );

  assign grant = idx_onehot & {N_REQ{grant_valid}};

endmodule
